// File: rtl/mux_nto1_rr_reg.sv
// Registered N:1 channel multiplexer with per-channel valid/ready handshake.
// Direct-select or round-robin arbitration feeding a one-entry output register.
module mux_nto1_rr_reg #(
    parameter int unsigned N    = 8,
    parameter int unsigned W    = 8,
    parameter int unsigned SELW = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            mode,
    input  logic [SELW-1:0] sel,
    input  logic [N*W-1:0]  in_data,
    input  logic [N-1:0]    in_valid,
    output logic [N-1:0]    in_ready,
    output logic [W-1:0]    out_data,
    output logic [SELW-1:0] out_chan,
    output logic            out_valid,
    input  logic            out_ready
);

    logic [W-1:0]    out_data_q, out_data_d;
    logic [SELW-1:0] out_chan_q, out_chan_d;
    logic            out_valid_q, out_valid_d;
    logic [SELW-1:0] rr_ptr_q, rr_ptr_d;

    logic [N-1:0]    grant;
    logic [SELW-1:0] gnt_idx;
    logic            gnt_any;
    logic            load_en;
    logic            xfer;
    logic [W-1:0]    chan_data [N];

    for (genvar i = 0; i < N; i++) begin : g_unpack
        assign chan_data[i] = in_data[i*W +: W];
    end

    always_comb begin
        int unsigned idx;
        logic [SELW-1:0] idx_s;
        grant   = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        idx     = 0;
        idx_s   = '0;
        if (!mode) begin
            // Out-of-range select issues no grant rather than aliasing a channel.
            if (32'(sel) < N) begin
                if (in_valid[sel]) begin
                    grant[sel] = 1'b1;
                    gnt_idx    = sel;
                    gnt_any    = 1'b1;
                end
            end
        end else begin
            // Search starts just after the last granted channel, wrapping modulo N.
            for (int unsigned k = 1; k <= N; k++) begin
                idx   = (32'(rr_ptr_q) + k) % N;
                idx_s = SELW'(idx);
                if (!gnt_any && in_valid[idx_s]) begin
                    grant[idx_s] = 1'b1;
                    gnt_idx      = idx_s;
                    gnt_any      = 1'b1;
                end
            end
        end
    end

    // Ready is withheld while reset is asserted so nothing is consumed then.
    assign load_en  = rst_n & (~out_valid_q | out_ready);
    assign in_ready = grant & {N{load_en}};
    assign xfer     = gnt_any & load_en;

    always_comb begin
        out_data_d  = out_data_q;
        out_chan_d  = out_chan_q;
        out_valid_d = out_valid_q;
        rr_ptr_d    = rr_ptr_q;
        if (xfer) begin
            out_data_d  = chan_data[gnt_idx];
            out_chan_d  = gnt_idx;
            out_valid_d = 1'b1;
            rr_ptr_d    = gnt_idx;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q  <= '0;
            out_chan_q  <= '0;
            out_valid_q <= 1'b0;
            rr_ptr_q    <= SELW'(N - 1);
        end else begin
            out_data_q  <= out_data_d;
            out_chan_q  <= out_chan_d;
            out_valid_q <= out_valid_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_chan  = out_chan_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mux_nto1_rr_reg.sv
// Bench for mux_nto1_rr_reg: directed vectors plus a per-cycle compare against
// a distance-based arbitration model.
module tb_mux_nto1_rr_reg;

    localparam int N    = 8;
    localparam int W    = 8;
    localparam int SELW = 3;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic            mode = 1'b0;
    logic [SELW-1:0] sel = '0;
    logic [N*W-1:0]  in_data = '0;
    logic [N-1:0]    in_valid = '0;
    logic [N-1:0]    in_ready;
    logic [W-1:0]    out_data;
    logic [SELW-1:0] out_chan;
    logic            out_valid;
    logic            out_ready = 1'b0;

    int tests = 0;
    int fails = 0;

    // Model state: output register contents and last granted channel.
    logic         mv;
    logic [W-1:0] md;
    int           mc;
    int           mp;
    logic         chk_en = 1'b0;

    mux_nto1_rr_reg #(.N(N), .W(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .mode     (mode),
        .sel      (sel),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_data (out_data),
        .out_chan (out_chan),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Round-robin winner: valid channel at the smallest forward distance past mp.
    function automatic int exp_grant();
        int best  = -1;
        int bestd = N;
        int d;
        if (!mode) begin
            if (int'(sel) < N && in_valid[sel]) return int'(sel);
            return -1;
        end
        for (int c = 0; c < N; c++) begin
            if (in_valid[c]) begin
                d = (c - mp - 1 + 2 * N) % N;
                if (d < bestd) begin
                    bestd = d;
                    best  = c;
                end
            end
        end
        return best;
    endfunction

    function automatic logic [N-1:0] exp_ready();
        int g;
        if (!rst_n) return '0;
        if (mv && !out_ready) return '0;
        g = exp_grant();
        if (g < 0) return '0;
        return N'(1) << g;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        int g;
        if (!rst_n) begin
            mv <= 1'b0;
            md <= '0;
            mc <= 0;
            mp <= N - 1;
        end else begin
            g = exp_grant();
            if ((!mv || out_ready) && g >= 0) begin
                mv <= 1'b1;
                md <= in_data[g*W +: W];
                mc <= g;
                mp <= g;
            end else if (out_ready) begin
                mv <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model in_ready", in_ready, exp_ready());
            check("model out_valid", out_valid, mv);
            if (mv) begin
                check("model out_data", out_data, md);
                check("model out_chan", out_chan, mc);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_default_data();
        for (int c = 0; c < N; c++) in_data[c*W +: W] = 8'(8'h10 + c);
    endtask

    initial begin
        // 1: reset with every channel valid
        mode      = 1'b1;
        in_valid  = '1;
        out_ready = 1'b1;
        load_default_data();
        #2 rst_n = 1'b0;
        #1;
        check("t1 rst out_valid", out_valid, 1'b0);
        check("t1 rst in_ready", in_ready, 8'h00);
        chk_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("t1 rst in_ready held", in_ready, 8'h00);
        rst_n = 1'b1;
        #1;
        check("t1 first ready", in_ready, 8'h01);
        tick();
        check("t1 first chan", out_chan, 0);
        check("t1 first data", out_data, 8'h10);
        check("t1 first valid", out_valid, 1'b1);

        // 2: direct select of channel 5
        mode     = 1'b0;
        sel      = 3'd5;
        in_valid = 8'h20;
        in_data[5*W +: W] = 8'hA5;
        #1;
        check("t2 in_ready", in_ready, 8'h20);
        tick();
        check("t2 out_data", out_data, 8'hA5);
        check("t2 out_chan", out_chan, 5);
        check("t2 out_valid", out_valid, 1'b1);

        // 3: round-robin sweep from a fresh reset
        rst_n = 1'b0;
        #1 rst_n = 1'b1;
        mode     = 1'b1;
        in_valid = 8'hFF;
        load_default_data();
        for (int i = 0; i < 10; i++) begin
            tick();
            check("t3 rr chan", out_chan, i % 8);
            check("t3 rr data", out_data, 8'(8'h10 + i % 8));
            check("t3 one-hot ready", $countones(in_ready), 1);
        end

        // 4: wrap-around with pointer at 1
        in_valid = 8'b1000_0010;
        tick();
        check("t4 wrap chan7", out_chan, 7);
        check("t4 wrap data7", out_data, 8'h17);
        tick();
        check("t4 wrap chan1", out_chan, 1);
        check("t4 wrap data1", out_data, 8'h11);

        // No grant with the consumer ready empties the register
        in_valid = '0;
        tick();
        check("drain empty", out_valid, 1'b0);

        // 5: hold a full word under backpressure, then drain and refill together
        mode     = 1'b0;
        sel      = 3'd2;
        in_valid = 8'h04;
        in_data[2*W +: W] = 8'h3C;
        tick();
        check("t5 load data", out_data, 8'h3C);
        check("t5 load chan", out_chan, 2);
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mode     = i[0];
            sel      = 3'(i + 1);
            in_valid = N'($urandom);
            in_data  = {$urandom, $urandom};
            #1;
            check("t5 hold ready", in_ready, 8'h00);
            tick();
            check("t5 hold data", out_data, 8'h3C);
            check("t5 hold chan", out_chan, 2);
            check("t5 hold valid", out_valid, 1'b1);
        end
        mode      = 1'b0;
        sel       = 3'd6;
        in_valid  = 8'h40;
        in_data[6*W +: W] = 8'h77;
        out_ready = 1'b1;
        #1;
        check("t5 refill ready", in_ready, 8'h40);
        tick();
        check("t5 refill data", out_data, 8'h77);
        check("t5 refill chan", out_chan, 6);
        check("t5 refill valid", out_valid, 1'b1);

        // 6: asynchronous reset while full
        out_ready = 1'b0;
        mode      = 1'b1;
        in_valid  = 8'hFF;
        load_default_data();
        #2 rst_n = 1'b0;
        #1;
        check("t6 async valid", out_valid, 1'b0);
        check("t6 async data", out_data, 8'h00);
        check("t6 async chan", out_chan, 0);
        tick();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        tick();
        check("t6 restart chan", out_chan, 0);
        check("t6 restart data", out_data, 8'h10);
        tick();
        check("t6 next chan", out_chan, 1);

        @(negedge clk);
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
